pwm_deadtime: RTL

- Sits directly downstream of pwmchannel and consumes its single-ended pwm_out.
- Produces a complementary high-side/low-side gate-drive pair with programmable dead time, so both switches are never on together.
- Pulses shorter than the dead time are dropped, and a saturating count of dropped pulses is kept for software.
- The dead-time value is buffered and sampled only at the start of each dead interval.

---
 rtl/pwm_deadtime.sv | 70 +++++++
 1 files changed

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: complementary gate-drive pair with programmable dead time and dropped-pulse counter
module pwm_deadtime #(
  parameter int DT_BITS   = 16,
  parameter int DEAD_RST  = 4,
  parameter int DROP_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pwm_in,
  input  logic                 enable,
  input  logic [DT_BITS-1:0]   dead_in,
  input  logic                 dead_wen,
  input  logic                 drop_clr,
  output logic                 out_hi,
  output logic                 out_lo,
  output logic                 dead_active,
  output logic [DROP_BITS-1:0] drop_cnt
);
  typedef enum logic [2:0] {OFF, LO_ON, DEAD_R, HI_ON, DEAD_F} state_t;
  state_t state, nxt;
  logic pwm_q, drop, dz;
  logic [DT_BITS-1:0] cnt, cnt_nxt, dead_buff;
  assign dz = dead_buff == '0;
  // next state, dead counter and drop detection; cnt loads only on entry to a dead state
  always_comb begin
    nxt = state;
    cnt_nxt = cnt;
    drop = 1'b0;
    if (!enable) nxt = OFF;
    else case (state)
      OFF:    nxt = pwm_q ? (dz ? HI_ON : DEAD_R) : LO_ON;
      LO_ON:  nxt = pwm_q ? (dz ? HI_ON : DEAD_R) : LO_ON;
      DEAD_R: begin
        drop = !pwm_q;
        nxt = !pwm_q ? LO_ON : (cnt == DT_BITS'(1)) ? HI_ON : DEAD_R;
        cnt_nxt = cnt - 1'b1;
      end
      HI_ON:  nxt = !pwm_q ? (dz ? LO_ON : DEAD_F) : HI_ON;
      DEAD_F: begin
        drop = pwm_q;
        nxt = pwm_q ? HI_ON : (cnt == DT_BITS'(1)) ? LO_ON : DEAD_F;
        cnt_nxt = cnt - 1'b1;
      end
      default: nxt = OFF;
    endcase
    if ((nxt == DEAD_R || nxt == DEAD_F) && nxt != state) cnt_nxt = dead_buff;
  end
  // state, input sync, dead-time buffer, decoded outputs and saturating drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= OFF;
      pwm_q       <= 1'b0;
      cnt         <= '0;
      dead_buff   <= DT_BITS'(DEAD_RST);
      out_hi      <= 1'b0;
      out_lo      <= 1'b0;
      dead_active <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      state       <= nxt;
      pwm_q       <= pwm_in;
      cnt         <= cnt_nxt;
      dead_buff   <= dead_wen ? dead_in : dead_buff;
      out_hi      <= nxt == HI_ON;
      out_lo      <= nxt == LO_ON;
      dead_active <= nxt == DEAD_R || nxt == DEAD_F;
      drop_cnt    <= drop_clr ? DROP_BITS'(drop) : (drop && !(&drop_cnt)) ? drop_cnt + 1'b1 : drop_cnt;
    end
  end
endmodule
